// File: rtl/fifo_rd_pkg.sv
// Shared types and default sizes for the FIFO read-side engine.
package fifo_rd_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        READ     = 2'd1,
        WAIT_OUT = 2'd2,
        DONE     = 2'd3
    } rd_state_e;

    localparam int DEF_FIFO_WIDTH = 16;
    localparam int DEF_LEN_W      = 8;

endpackage

// File: rtl/fifo_read_master_if.sv
// FIFO read port plus outgoing valid/ready stream, seen from the read engine.
interface fifo_read_master_if
    import fifo_rd_pkg::*;
#(
    parameter int FIFO_WIDTH = DEF_FIFO_WIDTH
);
    logic                  fifo_empty;
    logic [FIFO_WIDTH-1:0] fifo_data_out;
    logic                  fifo_underflow;
    logic                  fifo_rd_en;
    logic [FIFO_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;

    modport master (
        input  fifo_empty, fifo_data_out, fifo_underflow, m_ready,
        output fifo_rd_en, m_data, m_valid
    );

    modport slave (
        output fifo_empty, fifo_data_out, fifo_underflow, m_ready,
        input  fifo_rd_en, m_data, m_valid
    );
endinterface

// File: rtl/fifo_rd_skid.sv
// Two-entry in-order buffer; head is always the oldest stored word.
module fifo_rd_skid
    import fifo_rd_pkg::*;
#(
    parameter int FIFO_WIDTH = DEF_FIFO_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [FIFO_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [FIFO_WIDTH-1:0] head,
    output logic [1:0]            occ
);
    logic [FIFO_WIDTH-1:0] ent0_r;
    logic [FIFO_WIDTH-1:0] ent1_r;
    logic [1:0]            occ_r;

    // Entry storage and occupancy; push at occ==2 and pop at occ==0 never occur.
    always_ff @(posedge clk) begin
        if (rst) begin
            ent0_r <= {FIFO_WIDTH{1'b0}};
            ent1_r <= {FIFO_WIDTH{1'b0}};
            occ_r  <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ_r == 2'd0) begin
                        ent0_r <= push_data;
                    end else begin
                        ent1_r <= push_data;
                    end
                    occ_r <= occ_r + 2'd1;
                end
                2'b01: begin
                    ent0_r <= ent1_r;
                    occ_r  <= occ_r - 2'd1;
                end
                2'b11: begin
                    if (occ_r == 2'd1) begin
                        ent0_r <= push_data;
                    end else begin
                        ent0_r <= ent1_r;
                        ent1_r <= push_data;
                    end
                end
                default: begin
                    occ_r <= occ_r;
                end
            endcase
        end
    end

    assign head = ent0_r;
    assign occ  = occ_r;

endmodule

// File: rtl/fifo_read_master.sv
// Burst read engine: pops N words from the FIFO and re-presents them on a
// valid/ready stream through a 2-entry skid buffer.
module fifo_read_master
    import fifo_rd_pkg::*;
#(
    parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
    parameter int LEN_W      = DEF_LEN_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_start,
    input  logic [LEN_W-1:0]         cmd_len,
    fifo_read_master_if.master       bus,
    output logic                     busy,
    output logic                     done,
    output logic [LEN_W-1:0]         rd_count,
    output logic                     underflow_err
);
    rd_state_e             state_r;
    rd_state_e             state_nxt_s;
    logic [LEN_W-1:0]      len_r;
    logic [LEN_W-1:0]      issued_r;
    logic [LEN_W-1:0]      rd_count_r;
    logic                  inflight_r;
    logic                  underflow_err_r;
    logic [1:0]            occ_s;
    logic [FIFO_WIDTH-1:0] head_s;
    logic                  pop_s;
    logic                  rd_en_s;
    logic [2:0]            level_s;

    assign pop_s   = bus.m_valid && bus.m_ready;
    // Words buffered plus the one in flight, after this cycle's pop, must leave room.
    assign level_s = {1'b0, occ_s} + {2'b00, inflight_r} - {2'b00, pop_s};
    assign rd_en_s = !rst && (state_r == READ) && !bus.fifo_empty &&
                     (issued_r < len_r) && (level_s < 3'd2);

    assign bus.fifo_rd_en = rd_en_s;
    assign bus.m_valid    = (occ_s != 2'd0);
    assign bus.m_data     = head_s;
    assign busy           = (state_r != IDLE);
    assign done           = (state_r == DONE);
    assign rd_count       = rd_count_r;
    assign underflow_err  = underflow_err_r;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (cmd_start) begin
                    state_nxt_s = (cmd_len == {LEN_W{1'b0}}) ? DONE : READ;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            READ: begin
                if (rd_en_s && ((issued_r + LEN_W'(1'b1)) == len_r)) begin
                    state_nxt_s = WAIT_OUT;
                end else begin
                    state_nxt_s = READ;
                end
            end
            WAIT_OUT: begin
                if (!inflight_r && ((occ_s == 2'd0) || ((occ_s == 2'd1) && pop_s))) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = WAIT_OUT;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Burst bookkeeping: length, issue/delivery counters, read-in-flight, sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_r           <= {LEN_W{1'b0}};
            issued_r        <= {LEN_W{1'b0}};
            rd_count_r      <= {LEN_W{1'b0}};
            inflight_r      <= 1'b0;
            underflow_err_r <= 1'b0;
        end else begin
            inflight_r <= rd_en_s;
            if ((state_r == IDLE) && cmd_start) begin
                len_r           <= cmd_len;
                issued_r        <= {LEN_W{1'b0}};
                rd_count_r      <= {LEN_W{1'b0}};
                underflow_err_r <= 1'b0;
            end else begin
                if (rd_en_s) begin
                    issued_r <= issued_r + LEN_W'(1'b1);
                end
                if (pop_s && (rd_count_r != len_r)) begin
                    rd_count_r <= rd_count_r + LEN_W'(1'b1);
                end
                if (bus.fifo_underflow && busy) begin
                    underflow_err_r <= 1'b1;
                end
            end
        end
    end

    fifo_rd_skid #(
        .FIFO_WIDTH (FIFO_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_r),
        .push_data (bus.fifo_data_out),
        .pop       (pop_s),
        .head      (head_s),
        .occ       (occ_s)
    );

endmodule

// File: tb/tb_fifo_read_master.sv
// Directed and randomized bench for fifo_read_master with a queue-based FIFO model.
module tb_fifo_read_master;
    import fifo_rd_pkg::*;

    localparam int W  = 16;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_start;
    logic [LW-1:0] cmd_len;
    logic          busy;
    logic          done;
    logic [LW-1:0] rd_count;
    logic          underflow_err;

    fifo_read_master_if #(.FIFO_WIDTH(W)) bus ();

    fifo_read_master #(.FIFO_WIDTH(W), .LEN_W(LW)) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_start     (cmd_start),
        .cmd_len       (cmd_len),
        .bus           (bus),
        .busy          (busy),
        .done          (done),
        .rd_count      (rd_count),
        .underflow_err (underflow_err)
    );

    logic [W-1:0] fifo_mem[$];
    logic [W-1:0] got[$];
    logic [W-1:0] exp_q[$];
    int           rd_cyc[$];
    int           hs_cyc[$];
    int           cyc       = 0;
    int           t0        = 0;
    int           done_n    = 0;
    int           done_cyc  = 0;
    logic         rd_in_rst = 1'b0;
    int           checks    = 0;
    int           errors    = 0;
    int           b_rd, b_hs, b_dn;

    always #5 clk = ~clk;

    // FIFO model: one-cycle read latency, empty flag settles mid-cycle.
    always @(posedge clk) begin
        if (bus.fifo_rd_en && (fifo_mem.size() > 0)) bus.fifo_data_out <= fifo_mem.pop_front();
    end
    always @(negedge clk) bus.fifo_empty <= (fifo_mem.size() == 0);

    // Monitor: read cycles, stream handshakes and done pulses relative to the command cycle.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cmd_start && !busy && !rst) t0 <= cyc;
        if (bus.fifo_rd_en) rd_cyc.push_back(cyc - t0);
        if (bus.m_valid && bus.m_ready) begin
            got.push_back(bus.m_data);
            hs_cyc.push_back(cyc - t0);
        end
        if (done) begin
            done_n   <= done_n + 1;
            done_cyc <= cyc - t0;
        end
        if (rst && bus.fifo_rd_en) rd_in_rst <= 1'b1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start(input int n);
        cmd_len   = LW'(n);
        cmd_start = 1'b1;
        step();
        cmd_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        chk({tag, "_done_seen"}, 32'(done), 32'd1);
    endtask

    task automatic snap();
        b_rd = rd_cyc.size();
        b_hs = hs_cyc.size();
        b_dn = done_n;
    endtask

    initial begin
        // Reset with arbitrary inputs.
        rst                = 1'b1;
        cmd_start          = 1'($urandom_range(0, 1));
        cmd_len            = LW'($urandom);
        bus.m_ready        = 1'($urandom_range(0, 1));
        bus.fifo_underflow = 1'($urandom_range(0, 1));
        repeat (3) step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_valid", 32'(bus.m_valid), 32'd0);
        chk("rst_data", 32'(bus.m_data), 32'd0);
        chk("rst_rdcount", 32'(rd_count), 32'd0);
        chk("rst_uferr", 32'(underflow_err), 32'd0);
        rst = 1'b0; cmd_start = 1'b0; bus.fifo_underflow = 1'b0;
        step();
        chk("rst_no_rd_en", 32'(rd_in_rst), 32'd0);

        // Nominal burst of five.
        snap();
        for (int i = 0; i < 5; i++) fifo_mem.push_back(16'hA001 + W'(i));
        bus.m_ready = 1'b1;
        step();
        start(5);
        wait_done("nom", 40);
        chk("nom_rdcount", 32'(rd_count), 32'd5);
        step();
        chk("nom_nreads", rd_cyc.size() - b_rd, 5);
        for (int i = 0; i < 5; i++) begin
            chk("nom_rd_cyc", rd_cyc[b_rd + i], i + 1);
            chk("nom_hs_cyc", hs_cyc[b_hs + i], i + 3);
            chk("nom_data", 32'(got[b_hs + i]), 32'(16'hA001 + W'(i)));
        end
        chk("nom_done_cyc", done_cyc, 8);
        chk("nom_done_n", done_n - b_dn, 1);
        chk("nom_idle", 32'(busy), 32'd0);

        // Backpressure: only two reads fit while the stream is stalled.
        snap();
        for (int i = 0; i < 4; i++) fifo_mem.push_back(16'hB001 + W'(i));
        bus.m_ready = 1'b0;
        step();
        start(4);
        repeat (8) step();
        chk("bp_nreads", rd_cyc.size() - b_rd, 2);
        chk("bp_valid", 32'(bus.m_valid), 32'd1);
        for (int k = 0; k < 3; k++) begin
            chk("bp_hold", 32'(bus.m_data), 32'h0000B001);
            step();
        end
        bus.m_ready = 1'b1;
        wait_done("bp", 40);
        step();
        chk("bp_nhs", hs_cyc.size() - b_hs, 4);
        for (int i = 0; i < 4; i++) chk("bp_data", 32'(got[b_hs + i]), 32'(16'hB001 + W'(i)));
        chk("bp_done_n", done_n - b_dn, 1);

        // Empty FIFO stall, then data arrives.
        snap();
        start(3);
        repeat (6) step();
        chk("stall_no_rd", rd_cyc.size() - b_rd, 0);
        chk("stall_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 3; i++) fifo_mem.push_back(16'hC001 + W'(i));
        wait_done("stall", 40);
        chk("stall_rdcount", 32'(rd_count), 32'd3);
        step();
        for (int i = 0; i < 3; i++) chk("stall_data", 32'(got[b_hs + i]), 32'(16'hC001 + W'(i)));

        // Zero-length command.
        snap();
        start(0);
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_busy", 32'(busy), 32'd1);
        chk("zero_valid", 32'(bus.m_valid), 32'd0);
        step();
        chk("zero_busy_after", 32'(busy), 32'd0);
        chk("zero_done_after", 32'(done), 32'd0);
        step();
        chk("zero_no_rd", rd_cyc.size() - b_rd, 0);
        chk("zero_no_hs", hs_cyc.size() - b_hs, 0);
        chk("zero_done_n", done_n - b_dn, 1);

        // Underflow pulse mid-burst is sticky through done.
        snap();
        fifo_mem.push_back(16'hD001);
        fifo_mem.push_back(16'hD002);
        start(4);
        repeat (4) step();
        bus.fifo_underflow = 1'b1;
        step();
        bus.fifo_underflow = 1'b0;
        chk("uf_set", 32'(underflow_err), 32'd1);
        fifo_mem.push_back(16'hD003);
        fifo_mem.push_back(16'hD004);
        wait_done("uf", 40);
        chk("uf_at_done", 32'(underflow_err), 32'd1);
        step();

        // Reset with a full buffer discards it and never pulses done.
        snap();
        for (int i = 0; i < 4; i++) fifo_mem.push_back(16'hE001 + W'(i));
        bus.m_ready = 1'b0;
        step();
        start(4);
        chk("uf_cleared", 32'(underflow_err), 32'd0);
        repeat (5) step();
        chk("mrst_valid_before", 32'(bus.m_valid), 32'd1);
        rst = 1'b1;
        step();
        chk("mrst_valid", 32'(bus.m_valid), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_rdcount", 32'(rd_count), 32'd0);
        rst = 1'b0;
        bus.m_ready = 1'b1;
        repeat (4) step();
        chk("mrst_no_done", done_n - b_dn, 0);
        chk("mrst_no_rd_en", 32'(rd_in_rst), 32'd0);
        snap();
        start(2);
        wait_done("mrst_drain", 40);
        step();
        chk("mrst_drain0", 32'(got[b_hs]), 32'h0000E003);
        chk("mrst_drain1", 32'(got[b_hs + 1]), 32'h0000E004);

        // Randomized bursts against an in-order, exactly-N, latency>=2 reference.
        for (int b = 0; b < 20; b++) begin
            int len;
            int pi;
            int n;
            len = $urandom_range(1, 12);
            exp_q.delete();
            for (int i = 0; i < len; i++) exp_q.push_back(W'($urandom));
            snap();
            pi = 0;
            bus.m_ready = 1'($urandom_range(0, 1));
            start(len);
            n = 0;
            while (done !== 1'b1 && n < 400) begin
                if (pi < len && $urandom_range(0, 2) != 0) begin
                    fifo_mem.push_back(exp_q[pi]);
                    pi++;
                end
                bus.m_ready = ($urandom_range(0, 3) != 0);
                step();
                n++;
            end
            chk("rnd_done_seen", 32'(done), 32'd1);
            step();
            chk("rnd_nreads", rd_cyc.size() - b_rd, len);
            chk("rnd_nhs", hs_cyc.size() - b_hs, len);
            chk("rnd_rdcount", 32'(rd_count), 32'(len));
            chk("rnd_done_n", done_n - b_dn, 1);
            chk("rnd_uferr", 32'(underflow_err), 32'd0);
            for (int i = 0; i < len; i++) begin
                chk("rnd_data", 32'(got[b_hs + i]), 32'(exp_q[i]));
                chk("rnd_latency", 32'(hs_cyc[b_hs + i] >= rd_cyc[b_rd + i] + 2), 32'd1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_read_master.md
Name: fifo_read_master

Overview:
Synthesizable read-side engine for the team's synchronous FIFO.
- Accepts a burst command (length N) and pops exactly N words from the FIFO using rd_en, empty and data_out.
- Accounts for the FIFO's 1-cycle read latency and re-presents the words, in order, on a valid/ready stream through a 2-entry skid buffer.
- Is the consumer counterpart to the existing write-side stimulus, and sits between the FIFO and downstream logic.

Parameters:
FIFO_WIDTH, 16, data width of the FIFO and output stream
LEN_W, 8, width of the burst length and delivered-word counter

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous reset, active-high
cmd_start  in  1  start a burst; sampled only in IDLE
cmd_len  in  LEN_W  words to read; sampled with cmd_start
fifo_empty  in  1  FIFO empty flag
fifo_data_out  in  FIFO_WIDTH  FIFO read data, valid 1 cycle after an accepted read
fifo_underflow  in  1  FIFO underflow flag
fifo_rd_en  out  1  FIFO read enable
m_data  out  FIFO_WIDTH  stream data
m_valid  out  1  stream valid
m_ready  in  1  stream ready
busy  out  1  state != IDLE
done  out  1  1-cycle pulse at burst completion
rd_count  out  LEN_W  words delivered on the stream in the current or last burst
underflow_err  out  1  sticky: fifo_underflow seen while busy

Behaviour:
- Reset, synchronous and active-high: on the clock edge with rst=1, state=IDLE and every output/register is cleared, including buffer occupancy (occ), inflight, issued, rd_count and underflow_err.
  - fifo_rd_en is gated by !rst, so it is 0 in any cycle with rst=1.
  - Reset mid-burst discards the in-flight word and the buffered words, with no done pulse.
- FSM states:
  - IDLE: on cmd_start, latch len=cmd_len, clear issued, rd_count and underflow_err. Go to DONE if len==0, else to READ.
  - READ: issue reads. Go to WAIT_OUT when an accepted read makes issued==len.
  - WAIT_OUT: wait until inflight==0 and (occ==0, or occ==1 with a handshake this cycle), then go to DONE.
  - DONE: done=1 for exactly one cycle, then go to IDLE.
- Read issue (combinational):
  - fifo_rd_en = !rst && state==READ && !fifo_empty && issued<len && (occ + inflight - pop) < 2, where pop = m_valid && m_ready.
  - An accepted read increments issued and sets inflight for the next cycle.
- Capture: in any cycle with inflight=1, fifo_data_out is written to the buffer tail at the clock edge. inflight clears unless a new read is accepted in the same cycle.
- Buffer:
  - 2-entry, in order. m_valid = (occ != 0); m_data = head entry.
  - m_data is held stable while m_valid && !m_ready.
  - Simultaneous capture and pop leaves occ unchanged.
  - Occupancy can never exceed 2; the issue rule guarantees this.
- Latency: a word read at cycle t appears on m_valid at cycle t+2. With m_ready=1 and the FIFO non-empty, throughput is 1 word/cycle.
- rd_count increments on each handshake and saturates at len.
- underflow_err is set on any cycle with fifo_underflow=1 while busy. It is cleared only by rst or a new cmd_start.
- cmd_start while not IDLE is ignored.
- FIFO going empty mid-burst: rd_en drops and the state stays READ until data arrives; there is no timeout.

Decomposition:
- Shared package fifo_rd_pkg holds:
  - the rd_state_e enum (IDLE, READ, WAIT_OUT, DONE)
  - FIFO_WIDTH default 16
  - LEN_W default 8
- One sub-module, fifo_rd_skid: the 2-entry in-order buffer with ports push, push_data, pop, head, occ.

Test Plan:
- Reset: assert rst with any inputs. Next cycle, all outputs are 0, and fifo_rd_en is 0 during the rst cycles.
- Nominal burst: preload 0xA001..0xA005, cmd_len=5, m_ready=1.
  - fifo_rd_en is high in cycles 1-5.
  - m_data is 0xA001..0xA005 on consecutive cycles 3-7.
  - done is high in cycle 8; rd_count=5.
- Backpressure: preload 4 words, len=4, m_ready=0.
  - Exactly 2 reads are issued, then fifo_rd_en stays low.
  - m_data holds the first word.
  - Releasing m_ready delivers all 4 in order, followed by done.
- Empty stall: len=3 with the FIFO empty. fifo_rd_en stays 0 and busy=1. Writing 3 words completes the burst; rd_count=3.
- Zero length: cmd_start with cmd_len=0. done is high the next cycle, there is no fifo_rd_en and no m_valid, and busy is high 1 cycle.
- Error and reset mid-burst:
  - A fifo_underflow pulse during a burst sets underflow_err, which stays set through done.
  - rst mid-burst (occ=2) gives m_valid=0, busy=0 and done never pulses.
